trace_arbiter_mux: RTL and testbench

- Parametrised successor to the fixed 4-tile + NoC trace handler.
- Collects trace words from CH_NUM sources: per-tile trace buses plus the NoC trace bus.
- Each channel has its own small FIFO. A round-robin arbiter merges the channels into one tagged stream that feeds the trace buffer through a valid/ready handshake.
- Samples dropped under backpressure are counted and reported in-band as marker words.

---
 rtl/trace_arbiter_mux_if.sv | 25 ++
 rtl/trace_arbiter_mux.sv | 169 ++++++++++++++++
 tb/tb_trace_arbiter_mux.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_arbiter_mux_if.sv
// Output handshake bundle of the trace arbiter.
// Carries the tagged trace word towards the trace buffer.
interface trace_arbiter_mux_if #(
  parameter int DATAw  = 32,
  parameter int CH_NUM = 5
);
  localparam int CHw  = $clog2(CH_NUM);
  localparam int OUTw = 1 + CHw + DATAw;

  logic [OUTw-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/trace_arbiter_mux.sv
// Per-channel trace FIFOs merged round-robin into one tagged stream.
// Drops are counted per channel and reported as in-band marker words.
module trace_arbiter_mux #(
  parameter int DATAw      = 32,
  parameter int CH_NUM     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CNTw       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CH_NUM*DATAw-1:0] din_all,
  input  logic [CH_NUM-1:0]       wr_all,
  input  logic [CH_NUM-1:0]       ip_select,
  input  logic                    flush,
  trace_arbiter_mux_if.master     trc,
  output logic [CH_NUM-1:0]       overflow,
  output logic                    busy
);
  localparam int CHw  = $clog2(CH_NUM);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int OUTw = 1 + CHw + DATAw;

  localparam logic [CHw-1:0]  LAST = CHw'(CH_NUM - 1);
  localparam logic [AW:0]     FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CNTw-1:0] CMAX = '1;

  logic [DATAw-1:0] mem      [CH_NUM][FIFO_DEPTH];
  logic [AW-1:0]    wptr     [CH_NUM];
  logic [AW-1:0]    rptr     [CH_NUM];
  logic [AW:0]      cnt      [CH_NUM];
  logic [CNTw-1:0]  drop_cnt [CH_NUM];

  logic [CHw-1:0]  rr_ptr;
  logic [OUTw-1:0] dout_q;
  logic            dout_valid_q;

  logic              load;
  logic              gnt_vld;
  logic              gnt_hi;
  logic [CHw-1:0]    gnt;
  logic [OUTw-1:0]   gnt_word;
  logic [CH_NUM-1:0] pending;
  logic [CH_NUM-1:0] cap;
  logic [CH_NUM-1:0] pop;
  logic [CH_NUM-1:0] push;
  logic [CH_NUM-1:0] drop;
  logic [CH_NUM-1:0] mark;

  assign load = !dout_valid_q || trc.dout_ready;

  // Pending channels: queued data or an unreported drop count.
  always_comb begin
    pending = '0;
    for (int i = 0; i < CH_NUM; i++)
      pending[i] = (cnt[i] != '0) || (drop_cnt[i] != '0);
  end

  // Round-robin: lowest pending above rr_ptr, else lowest pending.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_hi  = 1'b0;
    gnt     = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (pending[i]) begin
        gnt_vld = 1'b1;
        gnt     = CHw'(i);
      end
    end
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (pending[i] && (CHw'(i) > rr_ptr)) begin
        gnt_hi = 1'b1;
        gnt    = CHw'(i);
      end
    end
  end

  // Per-channel push/pop/drop decisions and granted word mux.
  always_comb begin
    cap      = '0;
    pop      = '0;
    push     = '0;
    drop     = '0;
    mark     = '0;
    gnt_word = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      cap[i]  = wr_all[i] & ip_select[i];
      mark[i] = load && gnt_vld && (gnt == CHw'(i))
                && (drop_cnt[i] != '0);
      pop[i]  = load && gnt_vld && (gnt == CHw'(i))
                && (drop_cnt[i] == '0);
      push[i] = cap[i] && ((cnt[i] != FULL) || pop[i]);
      drop[i] = cap[i] && !push[i];
      if (gnt == CHw'(i)) begin
        if (drop_cnt[i] != '0)
          gnt_word = {1'b1, CHw'(i), DATAw'(drop_cnt[i])};
        else
          gnt_word = {1'b0, CHw'(i), mem[i][rptr[i]]};
      end
    end
  end

  // FIFO storage; contents need no reset since cnt gates reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH_NUM; i++)
      if (push[i] && !flush)
        mem[i][wptr[i]] <= din_all[i*DATAw +: DATAw];
  end

  // FIFO pointers, occupancy, drop counters and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        wptr[i]     <= '0;
        rptr[i]     <= '0;
        cnt[i]      <= '0;
        drop_cnt[i] <= '0;
      end
    end else if (flush) begin
      overflow <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        wptr[i]     <= '0;
        rptr[i]     <= '0;
        cnt[i]      <= '0;
        drop_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (push[i])
          wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])
          rptr[i] <= rptr[i] + 1'b1;
        if (push[i] && !pop[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (pop[i] && !push[i])
          cnt[i] <= cnt[i] - 1'b1;
        if (mark[i])
          drop_cnt[i] <= drop[i] ? CNTw'(1) : '0;
        else if (drop[i] && (drop_cnt[i] != CMAX))
          drop_cnt[i] <= drop_cnt[i] + 1'b1;
        if (drop[i])
          overflow[i] <= 1'b1;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      rr_ptr       <= LAST;
    end else if (flush) begin
      dout_valid_q <= 1'b0;
      rr_ptr       <= LAST;
    end else if (load) begin
      dout_valid_q <= gnt_vld;
      if (gnt_vld) begin
        dout_q <= gnt_word;
        rr_ptr <= gnt;
      end
    end
  end

  assign trc.dout       = dout_q;
  assign trc.dout_valid = dout_valid_q;
  assign busy           = dout_valid_q || (|pending);

endmodule

// File: tb/tb_trace_arbiter_mux.sv
// Scenario bench for trace_arbiter_mux.
// Expected words are queued at stimulus time, compared on handshake.
module tb_trace_arbiter_mux;
  localparam int DATAw  = 32;
  localparam int CH_NUM = 5;
  localparam int CHw    = 3;
  localparam int OUTw   = 1 + CHw + DATAw;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [CH_NUM*DATAw-1:0] din_all = '0;
  logic [CH_NUM-1:0]       wr_all = '0;
  logic [CH_NUM-1:0]       ip_select = '1;
  logic                    flush = 1'b0;
  logic [CH_NUM-1:0]       overflow;
  logic                    busy;

  logic [OUTw-1:0] exp_q [$];
  logic [OUTw-1:0] mon_exp;
  int checks = 0;
  int errors = 0;

  trace_arbiter_mux_if #(.DATAw(DATAw), .CH_NUM(CH_NUM)) trc ();

  trace_arbiter_mux #(
    .DATAw(DATAw), .CH_NUM(CH_NUM), .FIFO_DEPTH(4), .CNTw(8)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .din_all(din_all),
    .wr_all(wr_all),
    .ip_select(ip_select),
    .flush(flush),
    .trc(trc),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [OUTw-1:0] word(input logic m, input int ch,
                                           input logic [DATAw-1:0] d);
    return {m, ch[CHw-1:0], d};
  endfunction

  // Scoreboard: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (rst_n && trc.dout_valid && trc.dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got %h need none", trc.dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (trc.dout !== mon_exp) begin
          errors++;
          $display("FAIL stream_word got %h need %h", trc.dout, mon_exp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_all = '0;
    ip_select = '1;
    flush = 1'b0;
    din_all = '0;
    trc.dout_ready = 1'b0;
    exp_q.delete();
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout left %0d need 0", exp_q.size());
      exp_q.delete();
    end
    cyc(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (trc.dout !== '0) begin
      errors++; $display("FAIL rst_dout got %h need 0", trc.dout);
    end
    if (trc.dout_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b need 0", trc.dout_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b need 0", busy);
    end
    if (overflow !== '0) begin
      errors++; $display("FAIL rst_ovf got %b need 0", overflow);
    end
  endtask

  task automatic test_single();
    do_reset();
    trc.dout_ready = 1'b1;
    din_all[31:0] = 32'hA5A5_0001;
    wr_all = 5'b00001;
    exp_q.push_back(word(1'b0, 0, 32'hA5A5_0001));
    cyc(1);
    wr_all = '0;
    checks++;
    if (trc.dout_valid !== 1'b0) begin
      errors++; $display("FAIL single_early got %b need 0", trc.dout_valid);
    end
    cyc(1);
    checks += 3;
    if (trc.dout_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid got %b need 1", trc.dout_valid);
    end
    if (trc.dout !== 36'h0_A5A5_0001) begin
      errors++; $display("FAIL single_dout got %h need 0a5a50001", trc.dout);
    end
    if (busy !== 1'b1) begin
      errors++; $display("FAIL single_busy got %b need 1", busy);
    end
    cyc(1);
    checks += 3;
    if (trc.dout_valid !== 1'b0) begin
      errors++; $display("FAIL single_done got %b need 0", trc.dout_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_idle got %b need 0", busy);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL single_q got %0d need 0", exp_q.size());
    end
  endtask

  task automatic test_all_channels();
    logic [DATAw-1:0] d;
    do_reset();
    trc.dout_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < CH_NUM; i++) begin
        d = 32'hC000_0000 + b * 16 + i;
        din_all[i*DATAw +: DATAw] = d;
        exp_q.push_back(word(1'b0, i, d));
      end
      wr_all = '1;
      cyc(1);
      wr_all = '0;
      cyc(1);
      for (int k = 0; k < CH_NUM; k++) begin
        d = 32'hC000_0000 + b * 16 + k;
        checks++;
        if (trc.dout_valid !== 1'b1 || trc.dout !== word(1'b0, k, d)) begin
          errors++;
          $display("FAIL rr_order got %b/%h need 1/%h",
                   trc.dout_valid, trc.dout, word(1'b0, k, d));
        end
        cyc(1);
      end
    end
    drain(10);
  endtask

  task automatic test_backpressure();
    logic [DATAw-1:0] d;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      din_all[2*DATAw +: DATAw] = 32'hB200_0000 + k;
      wr_all = 5'b00100;
      cyc(1);
    end
    wr_all = '0;
    cyc(1);
    checks += 2;
    if (overflow !== 5'b00100) begin
      errors++; $display("FAIL bp_ovf got %b need 00100", overflow);
    end
    if (trc.dout !== word(1'b0, 2, 32'hB200_0000)) begin
      errors++; $display("FAIL bp_hold got %h need %h",
                         trc.dout, word(1'b0, 2, 32'hB200_0000));
    end
    exp_q.push_back(word(1'b0, 2, 32'hB200_0000));
    exp_q.push_back(word(1'b1, 2, 32'd1));
    for (int k = 1; k < 5; k++) begin
      d = 32'hB200_0000 + k;
      exp_q.push_back(word(1'b0, 2, d));
    end
    trc.dout_ready = 1'b1;
    drain(20);
    checks += 2;
    if (overflow !== 5'b00100) begin
      errors++; $display("FAIL bp_sticky got %b need 00100", overflow);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL bp_busy got %b need 0", busy);
    end
  endtask

  task automatic test_saturation();
    logic [DATAw-1:0] d;
    do_reset();
    for (int k = 0; k < 305; k++) begin
      din_all[1*DATAw +: DATAw] = 32'hD100_0000 + k;
      wr_all = 5'b00010;
      cyc(1);
    end
    wr_all = '0;
    cyc(1);
    checks++;
    if (overflow !== 5'b00010) begin
      errors++; $display("FAIL sat_ovf got %b need 00010", overflow);
    end
    exp_q.push_back(word(1'b0, 1, 32'hD100_0000));
    exp_q.push_back(word(1'b1, 1, 32'd255));
    for (int k = 1; k < 5; k++) begin
      d = 32'hD100_0000 + k;
      exp_q.push_back(word(1'b0, 1, d));
    end
    trc.dout_ready = 1'b1;
    drain(20);
  endtask

  task automatic test_mask();
    logic [DATAw-1:0] d;
    do_reset();
    ip_select = 5'b10001;
    trc.dout_ready = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      d = 32'hE000_0000 + i;
      din_all[i*DATAw +: DATAw] = d;
      if (i == 0 || i == 4)
        exp_q.push_back(word(1'b0, i, d));
    end
    wr_all = '1;
    cyc(1);
    wr_all = '0;
    drain(10);
    trc.dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = 32'hF000_0000 + k;
      din_all[31:0] = d;
      exp_q.push_back(word(1'b0, 0, d));
      wr_all = 5'b00001;
      cyc(1);
    end
    ip_select = 5'b10000;
    din_all[31:0] = 32'hDEAD_BEEF;
    cyc(3);
    wr_all = '0;
    checks++;
    if (overflow !== '0) begin
      errors++; $display("FAIL mask_ovf got %b need 0", overflow);
    end
    trc.dout_ready = 1'b1;
    drain(20);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mask_busy got %b need 0", busy);
    end
  endtask

  task automatic test_flush_and_reset();
    logic [DATAw-1:0] d;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      din_all[1*DATAw +: DATAw] = 32'h1100_0000 + k;
      din_all[3*DATAw +: DATAw] = 32'h3300_0000 + k;
      wr_all = (k < 2) ? 5'b01010 : 5'b01000;
      cyc(1);
    end
    wr_all = '0;
    cyc(1);
    checks += 2;
    if (overflow !== 5'b01000) begin
      errors++; $display("FAIL fl_pre_ovf got %b need 01000", overflow);
    end
    if (trc.dout_valid !== 1'b1) begin
      errors++; $display("FAIL fl_pre_valid got %b need 1", trc.dout_valid);
    end
    flush = 1'b1;
    wr_all = 5'b00001;
    cyc(1);
    flush = 1'b0;
    wr_all = '0;
    checks += 3;
    if (trc.dout_valid !== 1'b0) begin
      errors++; $display("FAIL fl_valid got %b need 0", trc.dout_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL fl_busy got %b need 0", busy);
    end
    if (overflow !== '0) begin
      errors++; $display("FAIL fl_ovf got %b need 0", overflow);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL fl_strobe got %b need 0", busy);
    end
    trc.dout_ready = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      d = 32'h5500_0000 + i;
      din_all[i*DATAw +: DATAw] = d;
      exp_q.push_back(word(1'b0, i, d));
    end
    wr_all = '1;
    cyc(1);
    wr_all = '0;
    cyc(2);
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (trc.dout !== '0) begin
      errors++; $display("FAIL ar_dout got %h need 0", trc.dout);
    end
    if (trc.dout_valid !== 1'b0) begin
      errors++; $display("FAIL ar_valid got %b need 0", trc.dout_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ar_busy got %b need 0", busy);
    end
    if (overflow !== '0) begin
      errors++; $display("FAIL ar_ovf got %b need 0", overflow);
    end
    exp_q.delete();
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    trc.dout_ready = 1'b0;
    test_reset();
    test_single();
    test_all_channels();
    test_backpressure();
    test_saturation();
    test_mask();
    test_flush_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
